operand_fetch_stage: RTL and testbench
======================================

OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width.
REQ-002 SHALL have parameter REG_ADDR_W, default 5, register index width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port areset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port Flush, input, 1, discards the stage contents and the current input.
REQ-006 SHALL have ports In_Valid/In_Ready, input/output, 1 each, decode-side handshake.
REQ-007 SHALL have ports In_Rs1/In_Rs2/In_Rd, input, REG_ADDR_W; In_Reg_Write/In_Mem_Read, input, 1; In_Imm/In_PC, input, XLEN.
REQ-008 SHALL have ports Read_Register1/Read_Register2, output, REG_ADDR_W, register file read addresses.
REQ-009 SHALL have ports Read_Data1/Read_Data2, input, XLEN, register file read data.
REQ-010 SHALL have ports WB_Write_Enable, WB_Write_Register, WB_Write_Data, input, 1/REG_ADDR_W/XLEN, the writeback port driven into the register file this cycle.
REQ-011 SHALL have ports Out_Valid/Out_Ready, output/input, 1 each, execute-side handshake.
REQ-012 SHALL have ports Out_Operand1/Out_Operand2/Out_Imm/Out_PC, output, XLEN; Out_Rd, output, REG_ADDR_W; Out_Reg_Write/Out_Mem_Read, output, 1.
REQ-013 SHALL have port Stall_Count, output, 32, count of hazard stall cycles.

Function
REQ-014 Read_Register1/2 SHALL equal In_Rs1/In_Rs2 combinationally.
REQ-015 The stage SHALL be a one-entry pipeline register; the output fields SHALL change only on capture, flush or reset.
REQ-016 Hazard SHALL be In_Valid && Out_Valid && Out_Mem_Read && Out_Rd!=0 && (Out_Rd==In_Rs1 || Out_Rd==In_Rs2).
REQ-017 In_Ready SHALL be Flush || (!Hazard && (!Out_Valid || Out_Ready)).
REQ-018 Capture SHALL occur when In_Valid && In_Ready && !Flush; all output fields are loaded next edge and Out_Valid becomes 1.
REQ-019 When there is no capture and Out_Ready=1, Out_Valid SHALL become 0 next edge; a hazard therefore inserts exactly one bubble.
REQ-020 When Out_Valid=1 and Out_Ready=0, all outputs SHALL hold.
REQ-021 Operand selection per source: index 0 -> 0; else a WB match (WB_Write_Enable && WB_Write_Register==index) -> WB_Write_Data; else Read_DataN.
REQ-022 Flush SHALL take priority over capture and hazard; Out_Valid becomes 0 next edge, and the input is consumed and dropped.
REQ-023 Stall_Count SHALL increment by 1 on each cycle with In_Valid=1, Flush=0, and In_Ready=0 due to a hazard (REQ-016 or REQ-031), and SHALL saturate at 0xFFFFFFFF.
REQ-024 Output-side backpressure (Out_Ready=0 with no hazard) SHALL NOT be counted.

Reset
REQ-025 areset high at a rising edge SHALL force Out_Valid=0, Stall_Count=0, and all output data fields=0, overriding Flush and capture.
REQ-026 While areset=1, In_Ready SHALL be 0.
REQ-027 Reset asserted mid-stall SHALL discard the held entry; after reset, the first valid input SHALL be captured on the next edge.

Configuration
REQ-028 Macro OPERAND_FETCH_WB_BYPASS_EN SHALL control the writeback bypass.
REQ-029 With the macro defined, the selection in REQ-021 SHALL apply.
REQ-030 Without the macro, operands SHALL be Read_DataN, or 0 for index 0.
REQ-031 Without the macro, a nonzero WB match on In_Rs1 or In_Rs2 with In_Valid=1 SHALL also be a hazard (In_Ready=0 that cycle, counted in Stall_Count).

Structure
REQ-032 XLEN and REG_ADDR_W defaults and the operand-select encoding SHALL live in shared package riscv_pkg.
REQ-033 The operand selection SHALL be one sub-module, operand_bypass_mux, instantiated twice.

Verification
REQ-034 Scenario: x5 holds 7, In_Rs1=5, no WB -> Out_Operand1=7 one cycle later, Out_Valid=1.
REQ-035 Scenario: WB writes x5=0x55 in the same cycle as In_Rs1=5 -> with macro, Out_Operand1=0x55 and no stall; without macro, one stall and Stall_Count=1.
REQ-036 Scenario: load to x3 in stage, next In_Rs2=3 -> In_Ready=0 for one cycle, one bubble, Stall_Count=1, then capture.
REQ-037 Scenario: In_Rs1=0 while WB writes x0=0xFF -> Out_Operand1=0.
REQ-038 Scenario: Out_Ready=0 for 3 cycles -> outputs hold, Stall_Count unchanged; Flush during the hold -> Out_Valid=0 next edge.
REQ-039 Scenario: areset during a hazard stall -> Out_Valid=0 and Stall_Count=0 next edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared defaults and operand-select encoding for the operand fetch stage.
package riscv_pkg;

  localparam int XLEN_DEFAULT       = 32;
  localparam int REG_ADDR_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    OPSEL_ZERO = 2'd0,
    OPSEL_RF   = 2'd1,
    OPSEL_WB   = 2'd2
  } opsel_e;

endpackage

// File: rtl/operand_bypass_mux.sv
// Per-source operand select: x0 reads as zero, optional writeback forwarding,
// otherwise register file data. Also reports a nonzero writeback index match.
module operand_bypass_mux
  import riscv_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT,
  parameter bit BYPASS_EN  = 1'b0
) (
  input  logic [REG_ADDR_W-1:0] i_index,
  input  logic [XLEN-1:0]       i_rf_data,
  input  logic                  i_wb_en,
  input  logic [REG_ADDR_W-1:0] i_wb_reg,
  input  logic [XLEN-1:0]       i_wb_data,
  output logic                  o_wb_hit,
  output logic [XLEN-1:0]       o_operand
);

  opsel_e w_sel;

  assign o_wb_hit = i_wb_en && (i_wb_reg == i_index) && (i_index != '0);

  always_comb begin
    w_sel = OPSEL_RF;
    if (i_index == '0) begin
      w_sel = OPSEL_ZERO;
    end else if (BYPASS_EN && o_wb_hit) begin
      w_sel = OPSEL_WB;
    end
  end

  always_comb begin
    o_operand = i_rf_data;
    case (w_sel)
      OPSEL_ZERO: o_operand = '0;
      OPSEL_WB:   o_operand = i_wb_data;
      default:    o_operand = i_rf_data;
    endcase
  end

endmodule

// File: rtl/operand_fetch_stage.sv
// One-entry operand fetch pipeline register with load-use hazard stalling.
// OPERAND_FETCH_WB_BYPASS_EN enables writeback forwarding; otherwise a WB match stalls.
module operand_fetch_stage
  import riscv_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  Flush,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic [REG_ADDR_W-1:0] In_Rs1,
  input  logic [REG_ADDR_W-1:0] In_Rs2,
  input  logic [REG_ADDR_W-1:0] In_Rd,
  input  logic                  In_Reg_Write,
  input  logic                  In_Mem_Read,
  input  logic [XLEN-1:0]       In_Imm,
  input  logic [XLEN-1:0]       In_PC,
  output logic [REG_ADDR_W-1:0] Read_Register1,
  output logic [REG_ADDR_W-1:0] Read_Register2,
  input  logic [XLEN-1:0]       Read_Data1,
  input  logic [XLEN-1:0]       Read_Data2,
  input  logic                  WB_Write_Enable,
  input  logic [REG_ADDR_W-1:0] WB_Write_Register,
  input  logic [XLEN-1:0]       WB_Write_Data,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic [XLEN-1:0]       Out_Operand1,
  output logic [XLEN-1:0]       Out_Operand2,
  output logic [XLEN-1:0]       Out_Imm,
  output logic [XLEN-1:0]       Out_PC,
  output logic [REG_ADDR_W-1:0] Out_Rd,
  output logic                  Out_Reg_Write,
  output logic                  Out_Mem_Read,
  output logic [31:0]           Stall_Count
);

`ifdef OPERAND_FETCH_WB_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic                  r_valid;
  logic [XLEN-1:0]       r_operand1;
  logic [XLEN-1:0]       r_operand2;
  logic [XLEN-1:0]       r_imm;
  logic [XLEN-1:0]       r_pc;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_reg_write;
  logic                  r_mem_read;
  logic [31:0]           r_stall_count;

  logic [XLEN-1:0] w_operand1;
  logic [XLEN-1:0] w_operand2;
  logic            w_wb_hit1;
  logic            w_wb_hit2;
  logic            w_load_use;
  logic            w_wb_hazard;
  logic            w_hazard;
  logic            w_capture;
  logic            w_count_stall;

  assign Read_Register1 = In_Rs1;
  assign Read_Register2 = In_Rs2;

  operand_bypass_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .BYPASS_EN(BYPASS_EN)) u_mux1 (
    .i_index   (In_Rs1),
    .i_rf_data (Read_Data1),
    .i_wb_en   (WB_Write_Enable),
    .i_wb_reg  (WB_Write_Register),
    .i_wb_data (WB_Write_Data),
    .o_wb_hit  (w_wb_hit1),
    .o_operand (w_operand1)
  );

  operand_bypass_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W), .BYPASS_EN(BYPASS_EN)) u_mux2 (
    .i_index   (In_Rs2),
    .i_rf_data (Read_Data2),
    .i_wb_en   (WB_Write_Enable),
    .i_wb_reg  (WB_Write_Register),
    .i_wb_data (WB_Write_Data),
    .o_wb_hit  (w_wb_hit2),
    .o_operand (w_operand2)
  );

  // Load result is not available until after execute, so a dependent consumer must wait.
  assign w_load_use  = In_Valid && r_valid && r_mem_read && (r_rd != '0) &&
                       ((r_rd == In_Rs1) || (r_rd == In_Rs2));
  assign w_wb_hazard = !BYPASS_EN && In_Valid && (w_wb_hit1 || w_wb_hit2);
  assign w_hazard    = w_load_use || w_wb_hazard;

  assign In_Ready      = !areset && (Flush || (!w_hazard && (!r_valid || Out_Ready)));
  assign w_capture     = In_Valid && In_Ready && !Flush;
  assign w_count_stall = In_Valid && !Flush && w_hazard;

  always_ff @(posedge clk) begin
    if (areset) begin
      r_valid       <= 1'b0;
      r_operand1    <= '0;
      r_operand2    <= '0;
      r_imm         <= '0;
      r_pc          <= '0;
      r_rd          <= '0;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_stall_count <= '0;
    end else begin
      if (Flush) begin
        r_valid <= 1'b0;
      end else if (w_capture) begin
        r_valid     <= 1'b1;
        r_operand1  <= w_operand1;
        r_operand2  <= w_operand2;
        r_imm       <= In_Imm;
        r_pc        <= In_PC;
        r_rd        <= In_Rd;
        r_reg_write <= In_Reg_Write;
        r_mem_read  <= In_Mem_Read;
      end else if (Out_Ready) begin
        r_valid <= 1'b0;
      end
      if (w_count_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign Out_Valid     = r_valid;
  assign Out_Operand1  = r_operand1;
  assign Out_Operand2  = r_operand2;
  assign Out_Imm       = r_imm;
  assign Out_PC        = r_pc;
  assign Out_Rd        = r_rd;
  assign Out_Reg_Write = r_reg_write;
  assign Out_Mem_Read  = r_mem_read;
  assign Stall_Count   = r_stall_count;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage; expectations follow OPERAND_FETCH_WB_BYPASS_EN if defined.
module tb_operand_fetch_stage;

  logic        clk = 1'b0;
  logic        areset;
  logic        Flush;
  logic        In_Valid;
  logic        In_Ready;
  logic [4:0]  In_Rs1, In_Rs2, In_Rd;
  logic        In_Reg_Write, In_Mem_Read;
  logic [31:0] In_Imm, In_PC;
  logic [4:0]  Read_Register1, Read_Register2;
  logic [31:0] Read_Data1, Read_Data2;
  logic        WB_Write_Enable;
  logic [4:0]  WB_Write_Register;
  logic [31:0] WB_Write_Data;
  logic        Out_Valid, Out_Ready;
  logic [31:0] Out_Operand1, Out_Operand2, Out_Imm, Out_PC;
  logic [4:0]  Out_Rd;
  logic        Out_Reg_Write, Out_Mem_Read;
  logic [31:0] Stall_Count;

  logic [31:0] rf [32];
  int total = 0;
  int bad   = 0;
  logic [31:0] sc_exp;

  always #5 clk = ~clk;

  assign Read_Data1 = rf[Read_Register1];
  assign Read_Data2 = rf[Read_Register2];

  operand_fetch_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .areset(areset), .Flush(Flush),
    .In_Valid(In_Valid), .In_Ready(In_Ready),
    .In_Rs1(In_Rs1), .In_Rs2(In_Rs2), .In_Rd(In_Rd),
    .In_Reg_Write(In_Reg_Write), .In_Mem_Read(In_Mem_Read),
    .In_Imm(In_Imm), .In_PC(In_PC),
    .Read_Register1(Read_Register1), .Read_Register2(Read_Register2),
    .Read_Data1(Read_Data1), .Read_Data2(Read_Data2),
    .WB_Write_Enable(WB_Write_Enable), .WB_Write_Register(WB_Write_Register),
    .WB_Write_Data(WB_Write_Data),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Operand1(Out_Operand1), .Out_Operand2(Out_Operand2),
    .Out_Imm(Out_Imm), .Out_PC(Out_PC), .Out_Rd(Out_Rd),
    .Out_Reg_Write(Out_Reg_Write), .Out_Mem_Read(Out_Mem_Read),
    .Stall_Count(Stall_Count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic mr, input logic [31:0] pc);
    In_Valid     = v;
    In_Rs1       = rs1;
    In_Rs2       = rs2;
    In_Rd        = rd;
    In_Mem_Read  = mr;
    In_Reg_Write = 1'b1;
    In_Imm       = pc + 32'h4;
    In_PC        = pc;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
    rf[0] = 32'hDEAD_BEEF;
    rf[5] = 32'd7;
    areset = 1'b1; Flush = 1'b0; Out_Ready = 1'b1;
    WB_Write_Enable = 1'b0; WB_Write_Register = '0; WB_Write_Data = '0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    tick(); tick();

    // Reset state
    check("reset_in_ready", In_Ready, 1'b0);
    check("reset_out_valid", Out_Valid, 1'b0);
    check("reset_stall", Stall_Count, 32'd0);
    check("reset_op1", Out_Operand1, 32'd0);
    check("reset_pc", Out_PC, 32'd0);
    $display("txn reset: Out_Valid=%0d Stall_Count=%0d", Out_Valid, Stall_Count);
    areset = 1'b0;

    // Plain register read of x5
    drive(1'b1, 5'd5, 5'd2, 5'd6, 1'b0, 32'h100);
    settle();
    check("rdaddr1", Read_Register1, 5'd5);
    check("rdaddr2", Read_Register2, 5'd2);
    check("plain_in_ready", In_Ready, 1'b1);
    tick();
    check("plain_valid", Out_Valid, 1'b1);
    check("plain_op1", Out_Operand1, 32'd7);
    check("plain_op2", Out_Operand2, 32'h102);
    check("plain_rd", Out_Rd, 5'd6);
    check("plain_imm", Out_Imm, 32'h104);
    check("plain_pc", Out_PC, 32'h100);
    $display("txn plain: op1=%0h op2=%0h pc=%0h", Out_Operand1, Out_Operand2, Out_PC);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    tick();
    check("drain_valid", Out_Valid, 1'b0);

    // Writeback to x5 in the same cycle as the read
    drive(1'b1, 5'd5, 5'd0, 5'd7, 1'b0, 32'h140);
    WB_Write_Enable = 1'b1; WB_Write_Register = 5'd5; WB_Write_Data = 32'h55;
    settle();
`ifdef OPERAND_FETCH_WB_BYPASS_EN
    check("wb_in_ready", In_Ready, 1'b1);
    tick();
    rf[5] = 32'h55;
    WB_Write_Enable = 1'b0;
    sc_exp = 32'd0;
`else
    check("wb_in_ready", In_Ready, 1'b0);
    tick();
    rf[5] = 32'h55;
    WB_Write_Enable = 1'b0;
    sc_exp = 32'd1;
    check("wb_stall_valid", Out_Valid, 1'b0);
    check("wb_stall_count", Stall_Count, sc_exp);
    settle();
    check("wb_retry_ready", In_Ready, 1'b1);
    tick();
`endif
    check("wb_valid", Out_Valid, 1'b1);
    check("wb_op1", Out_Operand1, 32'h55);
    check("wb_pc", Out_PC, 32'h140);
    check("wb_count", Stall_Count, sc_exp);
    $display("txn wb: op1=%0h stall=%0d", Out_Operand1, Stall_Count);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    tick();

    // Load to x3 followed by a consumer of x3
    drive(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 32'h180);
    tick();
    check("load_valid", Out_Valid, 1'b1);
    check("load_memrd", Out_Mem_Read, 1'b1);
    drive(1'b1, 5'd4, 5'd3, 5'd8, 1'b0, 32'h200);
    settle();
    check("lu_in_ready", In_Ready, 1'b0);
    tick();
    sc_exp = sc_exp + 32'd1;
    check("lu_bubble", Out_Valid, 1'b0);
    check("lu_count", Stall_Count, sc_exp);
    settle();
    check("lu_retry_ready", In_Ready, 1'b1);
    tick();
    check("lu_valid", Out_Valid, 1'b1);
    check("lu_op2", Out_Operand2, 32'h103);
    check("lu_op1", Out_Operand1, 32'h104);
    check("lu_pc", Out_PC, 32'h200);
    $display("txn load-use: op2=%0h stall=%0d", Out_Operand2, Stall_Count);

    // x0 source while WB targets x0
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b0, 32'h240);
    WB_Write_Enable = 1'b1; WB_Write_Register = 5'd0; WB_Write_Data = 32'hFF;
    settle();
    check("x0_in_ready", In_Ready, 1'b1);
    tick();
    WB_Write_Enable = 1'b0;
    check("x0_op1", Out_Operand1, 32'd0);
    check("x0_op2", Out_Operand2, 32'd0);
    check("x0_count", Stall_Count, sc_exp);
    $display("txn x0: op1=%0h op2=%0h", Out_Operand1, Out_Operand2);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    tick();

    // Backpressure hold, then flush
    drive(1'b1, 5'd2, 5'd1, 5'd10, 1'b0, 32'h300);
    tick();
    Out_Ready = 1'b0;
    drive(1'b1, 5'd4, 5'd6, 5'd11, 1'b0, 32'h400);
    settle();
    check("bp_in_ready", In_Ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", Out_Valid, 1'b1);
      check("bp_pc", Out_PC, 32'h300);
      check("bp_op1", Out_Operand1, 32'h102);
      check("bp_count", Stall_Count, sc_exp);
    end
    Flush = 1'b1;
    settle();
    check("flush_in_ready", In_Ready, 1'b1);
    tick();
    check("flush_valid", Out_Valid, 1'b0);
    check("flush_hold_pc", Out_PC, 32'h300);
    $display("txn flush: Out_Valid=%0d pc=%0h", Out_Valid, Out_PC);
    Flush = 1'b0; Out_Ready = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0);
    tick();

    // Reset during a load-use stall
    drive(1'b1, 5'd1, 5'd0, 5'd3, 1'b1, 32'h480);
    tick();
    Out_Ready = 1'b0;
    drive(1'b1, 5'd3, 5'd0, 5'd12, 1'b0, 32'h500);
    tick();
    sc_exp = sc_exp + 32'd1;
    check("rst_stall_count", Stall_Count, sc_exp);
    check("rst_stall_held", Out_Valid, 1'b1);
    areset = 1'b1;
    settle();
    check("rst_in_ready", In_Ready, 1'b0);
    tick();
    check("rst_valid", Out_Valid, 1'b0);
    check("rst_count", Stall_Count, 32'd0);
    check("rst_pc", Out_PC, 32'd0);
    check("rst_op1", Out_Operand1, 32'd0);
    areset = 1'b0; Out_Ready = 1'b1;
    settle();
    check("post_rst_ready", In_Ready, 1'b1);
    tick();
    check("post_rst_valid", Out_Valid, 1'b1);
    check("post_rst_pc", Out_PC, 32'h500);
    check("post_rst_op1", Out_Operand1, 32'h103);
    check("post_rst_count", Stall_Count, 32'd0);
    $display("txn reset-stall: pc=%0h op1=%0h stall=%0d", Out_PC, Out_Operand1, Stall_Count);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
